// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a START/RUN/HALT
// controller with branch redirect, hazard stall and halt-on-HLT_WORD.
module fetch_stage #(
    parameter logic [31:0] HLT_WORD = 32'hD440_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        halted_q, halted_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        is_hlt;
    assign is_hlt = (imem_rdata == HLT_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            START: state_d = RUN;
            RUN: begin
                if (branch_taken)  state_d = RUN;
                else if (stall)    state_d = RUN;
                else if (is_hlt)   state_d = HALT;
                else               state_d = RUN;
            end
            HALT:    state_d = branch_taken ? RUN : HALT;
            default: state_d = START;
        endcase
    end

    // Datapath / output logic; a bubble keeps the PC of the squashed slot.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        misaligned_d  = misaligned_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            START: begin
                if_id_pc_d    = pc_q;
                if_id_instr_d = 32'h0000_0000;
                if_id_valid_d = 1'b0;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_d          = {branch_target[63:2], 2'b00};
                    misaligned_d  = misaligned_q | (branch_target[1:0] != 2'b00);
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = 32'h0000_0000;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (!is_hlt) begin
                        pc_d = pc_q + 64'd4;
                    end
                end
            end
            HALT: begin
                if (branch_taken) begin
                    pc_d          = {branch_target[63:2], 2'b00};
                    misaligned_d  = misaligned_q | (branch_target[1:0] != 2'b00);
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = 32'h0000_0000;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = 32'h0000_0000;
                    if_id_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= 64'd0;
            if_id_pc_q    <= 64'd0;
            if_id_instr_q <= 32'd0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            halted_q      <= halted_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr         = pc_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_valid       = if_id_valid_q;
    assign halted            = halted_q;
    assign misaligned        = misaligned_q;
    assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] HLT = 32'hD440_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'd0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Memory: word i = 8B00_0000+i, except addresses listed in hlt_addr hold HLT.
    logic [63:0] hlt_addr [4];

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
        .halted(halted), .misaligned(misaligned), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 32'h8B00_0000 + imem_addr[33:2];
        for (int i = 0; i < 4; i++) begin
            if (imem_addr == hlt_addr[i]) imem_rdata = HLT;
        end
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = 32'h8B00_0000 + 32'(a >> 2);
        for (int i = 0; i < 4; i++) begin
            if (a == hlt_addr[i]) w = HLT;
        end
        return w;
    endfunction

    // Behavioural model: "started" means the post-reset bubble has been issued.
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid, m_halted, m_mis, m_started;

    task automatic model_reset();
        m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0;
        m_halted = 0; m_mis = 0; m_cnt = 0; m_started = 0;
    endtask

    task automatic clear_hlt();
        for (int i = 0; i < 4; i++) hlt_addr[i] = 64'h1;
    endtask

    // Drive one cycle of inputs, advance the model, and settle #1 past the edge.
    task automatic cycle(input logic r, input logic s, input logic b, input logic [63:0] t);
        logic [31:0] w;
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        w = mem_word(m_pc);
        if (r) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1; m_ifpc = m_pc; m_instr = 0; m_valid = 0;
        end else if (b) begin
            m_mis = m_mis | (t[1:0] != 2'b00);
            m_ifpc = m_pc; m_instr = 0; m_valid = 0;
            m_pc = {t[63:2], 2'b00};
            m_halted = 0;
        end else if (s) begin
        end else if (m_halted) begin
            m_ifpc = m_pc; m_instr = 0; m_valid = 0;
        end else begin
            m_ifpc = m_pc; m_instr = w; m_valid = 1; m_cnt = m_cnt + 1;
            if (w == HLT) m_halted = 1;
            else m_pc = m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_hlt();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 64'h55);
        checks++;
        if ({imem_addr, if_id_pc, if_id_instruction, if_id_valid, halted, misaligned, fetch_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%h ifpc=%h instr=%h v=%b h=%b m=%b cnt=%0d expected all zero",
                     imem_addr, if_id_pc, if_id_instruction, if_id_valid, halted, misaligned, fetch_count);
        end
        cycle(0, 1, 1, 64'h80);  // START ignores stall/branch
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || imem_addr !== 64'h0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL start_bubble: v=%b instr=%h addr=%h cnt=%0d expected v=0 instr=0 addr=0 cnt=0",
                     if_id_valid, if_id_instruction, imem_addr, fetch_count);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instruction !== 32'h8B00_0000 || fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL first_fetch: v=%b pc=%h instr=%h cnt=%0d expected v=1 pc=0 instr=8b000000 cnt=1",
                     if_id_valid, if_id_pc, if_id_instruction, fetch_count);
        end
    endtask

    task automatic test_sequential_and_stall();
        logic [63:0] snap_pc;
        logic [31:0] snap_instr, snap_cnt;
        for (int i = 1; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (if_id_pc !== 64'(4 * i) || if_id_instruction !== 32'h8B00_0000 + 32'(i) ||
                if_id_valid !== 1'b1 || fetch_count !== 32'(i + 1)) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: pc=%h instr=%h v=%b cnt=%0d expected pc=%h instr=%h v=1 cnt=%0d",
                         i, if_id_pc, if_id_instruction, if_id_valid, fetch_count, 64'(4 * i),
                         32'h8B00_0000 + 32'(i), i + 1);
            end
        end
        snap_pc = if_id_pc; snap_instr = if_id_instruction; snap_cnt = fetch_count;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            checks++;
            if (if_id_pc !== snap_pc || if_id_instruction !== snap_instr || if_id_valid !== 1'b1 ||
                fetch_count !== snap_cnt || imem_addr !== 64'd12) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ifpc=%h instr=%h v=%b cnt=%0d addr=%h expected ifpc=8 instr=%h v=1 cnt=%0d addr=c",
                         i, if_id_pc, if_id_instruction, if_id_valid, fetch_count, imem_addr, snap_instr, snap_cnt);
            end
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (if_id_pc !== 64'd12 || if_id_instruction !== 32'h8B00_0003 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL stall_resume: pc=%h instr=%h cnt=%0d expected pc=c instr=8b000003 cnt=4",
                     if_id_pc, if_id_instruction, fetch_count);
        end
    endtask

    task automatic test_branch_with_stall();
        cycle(0, 1, 1, 64'h100);
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || imem_addr !== 64'h100 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL branch_bubble: v=%b instr=%h addr=%h cnt=%0d expected v=0 instr=0 addr=100 cnt=4",
                     if_id_valid, if_id_instruction, imem_addr, fetch_count);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (if_id_pc !== 64'h100 || if_id_valid !== 1'b1 || if_id_instruction !== 32'h8B00_0040 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL branch_target_fetch: pc=%h v=%b instr=%h mis=%b expected pc=100 v=1 instr=8b000040 mis=0",
                     if_id_pc, if_id_valid, if_id_instruction, misaligned);
        end
    endtask

    task automatic test_misaligned_and_wrap();
        cycle(0, 0, 1, 64'h102);
        checks++;
        if (imem_addr !== 64'h100 || misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_latch: addr=%h mis=%b expected addr=100 mis=1", imem_addr, misaligned);
        end
        cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 0, 0, 0);
        checks++;
        if (imem_addr !== 64'h0 || if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || misaligned !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: addr=%h ifpc=%h mis=%b expected addr=0 ifpc=fffffffffffffffc mis=1",
                     imem_addr, if_id_pc, misaligned);
        end
    endtask

    task automatic test_halt();
        clear_hlt();
        hlt_addr[0] = 64'h10;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);  // START bubble, then PC 0..0xc
        cycle(0, 0, 0, 0);
        checks++;
        if (if_id_pc !== 64'h10 || if_id_instruction !== HLT || if_id_valid !== 1'b1 ||
            halted !== 1'b1 || fetch_count !== 32'd5 || imem_addr !== 64'h10) begin
            errors++;
            $display("FAIL halt_entry: pc=%h instr=%h v=%b h=%b cnt=%0d addr=%h expected pc=10 instr=%h v=1 h=1 cnt=5 addr=10",
                     if_id_pc, if_id_instruction, if_id_valid, halted, fetch_count, imem_addr, HLT);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || halted !== 1'b1 ||
                imem_addr !== 64'h10 || fetch_count !== 32'd5) begin
                errors++;
                $display("FAIL halt_bubble[%0d]: v=%b instr=%h h=%b addr=%h cnt=%0d expected v=0 instr=0 h=1 addr=10 cnt=5",
                         i, if_id_valid, if_id_instruction, halted, imem_addr, fetch_count);
            end
        end
        cycle(0, 0, 1, 64'h40);
        checks++;
        if (halted !== 1'b0 || imem_addr !== 64'h40 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit: h=%b addr=%h v=%b expected h=0 addr=40 v=0", halted, imem_addr, if_id_valid);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (if_id_pc !== 64'h40 || if_id_instruction !== 32'h8B00_0010 || if_id_valid !== 1'b1 || fetch_count !== 32'd6) begin
            errors++;
            $display("FAIL halt_resume: pc=%h instr=%h v=%b cnt=%0d expected pc=40 instr=8b000010 v=1 cnt=6",
                     if_id_pc, if_id_instruction, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_reset_while_halted();
        hlt_addr[1] = 64'h48;
        cycle(0, 0, 1, 64'h45);  // misaligned redirect to 0x44
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);       // fetches HLT at 0x48
        checks++;
        if (halted !== 1'b1 || misaligned !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: h=%b mis=%b expected h=1 mis=1", halted, misaligned);
        end
        cycle(1, 1, 1, 64'h200);
        checks++;
        if ({imem_addr, if_id_pc, if_id_instruction, if_id_valid, halted, misaligned, fetch_count} !== '0) begin
            errors++;
            $display("FAIL reset_from_halt: addr=%h ifpc=%h instr=%h v=%b h=%b m=%b cnt=%0d expected all zero",
                     imem_addr, if_id_pc, if_id_instruction, if_id_valid, halted, misaligned, fetch_count);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 64'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_bubble: v=%b addr=%h h=%b expected v=0 addr=0 h=0", if_id_valid, imem_addr, halted);
        end
    endtask

    task automatic test_random();
        logic r, s, b;
        logic [63:0] t;
        clear_hlt();
        for (int i = 0; i < 4; i++) hlt_addr[i] = 64'($urandom_range(0, 127)) << 2;
        cycle(1, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 64'($urandom_range(0, 511));
            cycle(r, s, b, t);
            checks++;
            if (imem_addr !== m_pc || if_id_valid !== m_valid || if_id_instruction !== m_instr ||
                (m_valid && if_id_pc !== m_ifpc) || halted !== m_halted || misaligned !== m_mis ||
                fetch_count !== m_cnt) begin
                errors++;
                $display("FAIL random[%0d]: addr=%h ifpc=%h instr=%h v=%b h=%b m=%b cnt=%0d expected addr=%h ifpc=%h instr=%h v=%b h=%b m=%b cnt=%0d",
                         n, imem_addr, if_id_pc, if_id_instruction, if_id_valid, halted, misaligned, fetch_count,
                         m_pc, m_ifpc, m_instr, m_valid, m_halted, m_mis, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        clear_hlt();
        test_reset();
        test_sequential_and_stall();
        test_branch_with_stall();
        test_misaligned_and_wrap();
        test_halt();
        test_reset_while_halted();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 stall  input  1  hazard stall; hold PC and IF/ID contents.
REQ-005 branch_taken  input  1  redirect request from a later stage.
REQ-006 branch_target  input  64  redirect byte address.
REQ-007 imem_addr  output  64  instruction-memory address; always equals the current PC.
REQ-008 imem_rdata  input  32  instruction word at imem_addr, combinational, same cycle.
REQ-009 if_id_pc  output  64  PC of the instruction held in IF/ID.
REQ-010 if_id_instruction  output  32  instruction word delivered to decode.
REQ-011 if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-012 halted  output  1  fetch has stopped on HLT.
REQ-013 misaligned  output  1  sticky flag; a redirect target had bits [1:0] nonzero.
REQ-014 fetch_count  output  32  number of instructions loaded into IF/ID with valid=1.

Function
REQ-015 Parameter HLT_WORD, default 32'hD440_0000, SHALL define the halt encoding.
REQ-016 The FSM SHALL have three states: START, RUN and HALT; rst SHALL force START.
REQ-017 START SHALL last exactly one cycle: the PC is held, IF/ID is loaded with a bubble, and the next state is RUN.
REQ-018 In RUN, all conditions in REQ-019 to REQ-024 SHALL be evaluated in priority order, with the first match taken.
REQ-019 If branch_taken=1: PC <= {branch_target[63:2],2'b00}, IF/ID <= bubble, and misaligned <= misaligned | (branch_target[1:0]!=0).
REQ-020 Branch_taken SHALL have priority over stall.
REQ-021 If stall=1: PC, if_id_pc, if_id_instruction, if_id_valid and fetch_count SHALL all hold.
REQ-022 If imem_rdata==HLT_WORD: IF/ID <= {PC, imem_rdata, valid=1}, fetch_count += 1, PC holds, and the next state is HALT.
REQ-023 Otherwise: PC <= PC+4 (64-bit modulo, wrapping at 2^64), IF/ID <= {PC, imem_rdata, valid=1}, and fetch_count += 1.
REQ-024 Fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 A bubble SHALL be if_id_valid=0 and if_id_instruction=32'h0000_0000, with if_id_pc holding the PC of the slot.
REQ-026 In HALT: halted=1, and the PC holds.
REQ-027 In HALT, IF/ID SHALL be loaded with a bubble each cycle that stall=0, and SHALL hold when stall=1.
REQ-028 In HALT, branch_taken=1 SHALL apply the REQ-019 redirect and return the FSM to RUN; halted SHALL deassert in the next cycle.
REQ-029 In START, branch_taken and stall SHALL be ignored.
REQ-030 halted SHALL be a registered output, equal to 1 exactly when the state is HALT.
REQ-031 imem_addr SHALL be driven combinationally from the PC register.
REQ-032 Stall and branch_taken asserted in the same cycle SHALL behave as branch_taken alone.
REQ-033 A stall lasting N cycles SHALL leave all outputs unchanged for those N cycles.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL set: PC=0, if_id_pc=0, if_id_instruction=0, if_id_valid=0, halted=0, misaligned=0, fetch_count=0, state=START.
REQ-035 rst SHALL override every other input, including mid-stall, mid-redirect and in HALT.
REQ-036 Reset SHALL take effect on the clock edge at which rst is sampled high; there SHALL be no asynchronous path.
REQ-037 The first valid instruction SHALL appear in IF/ID two edges after rst deasserts: the START bubble, then PC 0.

Verification
REQ-038 Reset then sequential fetch: memory word[i] = 32'h8B00_0000+i, no stall -> if_id_pc = 0, 4, 8, … on consecutive cycles with matching words; fetch_count increments by 1 per cycle.
REQ-039 Stall for 3 cycles while IF/ID holds PC 8 -> IF/ID, PC (=12) and fetch_count stay frozen for 3 cycles, then fetch resumes at PC 12.
REQ-040 branch_taken with target 64'h100, asserted together with stall -> the next cycle shows a bubble in IF/ID; the cycle after shows if_id_pc=64'h100, valid=1.
REQ-041 Branch target 64'h102 -> PC becomes 64'h100 and misaligned latches 1, staying 1 until rst.
REQ-042 HLT_WORD at PC 64'h10 -> IF/ID gets the HLT with valid=1, halted=1, then bubbles only while PC stays 64'h10; a later branch to 64'h40 resumes fetch at 64'h40.
REQ-043 rst asserted while halted and misaligned=1 -> all outputs return to their REQ-034 values at the next edge, followed by the START bubble.
